// File: rtl/rng_draw.sv
// rtl/rng_draw.sv - Galois LFSR random draw with rejection sampling, reseed and no-repeat
module rng_draw #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
  parameter int                    SEED       = 42,
  parameter int                    OFFSET     = 0,
  parameter int                    MAX_VALUE  = 18,
  parameter int                    NO_REPEAT  = 0,
  parameter int                    MAX_TRIES  = 8,
  localparam int                   IDX_W      = $clog2(MAX_VALUE),
  localparam int                   OUT_W      = $clog2(OFFSET + MAX_VALUE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  output logic                  busy,
  output logic                  valid,
  output logic [OUT_W-1:0]      random_value
);

  localparam int TRY_W = $clog2(MAX_TRIES) + 1;

  // A zero state would lock the LFSR, so zero seeds are promoted to 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_INIT = (SEED == 0) ? LFSR_WIDTH'(1) : LFSR_WIDTH'(SEED);
  localparam logic [IDX_W:0]        MAX_IDX_X = (IDX_W + 1)'(MAX_VALUE);
  localparam logic [IDX_W-1:0]      TOP_IDX   = IDX_W'(MAX_VALUE - 1);
  localparam logic [TRY_W-1:0]      LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_W-1:0]      OFFSET_W  = OUT_W'(OFFSET);

  typedef enum logic {
    IDLE,
    DRAW
  } state_t;

  state_t                  state;
  logic [LFSR_WIDTH-1:0]   lfsr;
  logic [LFSR_WIDTH-1:0]   lfsr_step;
  logic [IDX_W-1:0]        candidate;
  logic [IDX_W-1:0]        last_idx;
  logic                    last_valid;
  logic [TRY_W-1:0]        tries;
  logic                    reject;
  logic                    last_try;
  logic [IDX_W-1:0]        fallback;
  logic [IDX_W-1:0]        pick;

  // Candidate evaluation from the current (pre-edge) LFSR state.
  always_comb begin
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    candidate = lfsr[IDX_W-1:0];
    reject    = ({1'b0, candidate} >= MAX_IDX_X) ||
                ((NO_REPEAT != 0) && last_valid && (candidate == last_idx));
    last_try  = (tries == LAST_TRY);
    // Fallback steps past the previous index so it can never repeat it.
    if (last_valid) begin
      fallback = (last_idx == TOP_IDX) ? '0 : last_idx + IDX_W'(1);
    end else begin
      fallback = '0;
    end
    pick = reject ? fallback : candidate;
  end

  // LFSR runs every cycle; a reseed overrides the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED_INIT;
    end else if (seed_load) begin
      lfsr <= (seed_in == '0) ? LFSR_WIDTH'(1) : seed_in;
    end else begin
      lfsr <= lfsr_step;
    end
  end

  // Draw FSM: accept a candidate, retry, or fall back after MAX_TRIES rejections.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      valid        <= 1'b0;
      random_value <= OFFSET_W;
      last_idx     <= '0;
      last_valid   <= 1'b0;
      tries        <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state <= DRAW;
            busy  <= 1'b1;
            tries <= '0;
          end
        end
        DRAW: begin
          if (!reject || last_try) begin
            random_value <= OFFSET_W + OUT_W'(pick);
            last_idx     <= pick;
            last_valid   <= 1'b1;
            valid        <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            tries <= tries + TRY_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_draw.sv
// tb/tb_rng_draw.sv - self-checking bench for rng_draw over four parameter sets
module tb_rng_draw;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        busy_o  [N];
  logic        valid_o [N];
  logic [4:0]  rv_o    [N];

  // instance configs: 0 default, 1 no-repeat, 2 offset 3, 3 single try
  int norep_p [N] = '{0, 1, 0, 0};
  int off_p   [N] = '{0, 0, 3, 0};
  int mt_p    [N] = '{8, 8, 8, 1};

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [15:0] m_lfsr;
  bit          m_lv [N];
  int          m_li [N];
  int          act_k [N];
  int          act_v [N];

  typedef struct {
    logic [15:0] seed;
    int v0, v1, v2, v3;
    int k0, k1, k2, k3;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  rng_draw u0 (.clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
               .busy(busy_o[0]), .valid(valid_o[0]), .random_value(rv_o[0]));
  rng_draw #(.NO_REPEAT(1)) u1 (.clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
               .busy(busy_o[1]), .valid(valid_o[1]), .random_value(rv_o[1]));
  rng_draw #(.OFFSET(3)) u2 (.clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
               .busy(busy_o[2]), .valid(valid_o[2]), .random_value(rv_o[2]));
  rng_draw #(.MAX_TRIES(1)) u3 (.clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
               .busy(busy_o[3]), .valid(valid_o[3]), .random_value(rv_o[3]));

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Walk the candidate sequence of one draw: returns edges taken and chosen index.
  task automatic predict(input int i, input logic [15:0] s, output int k, output int idx);
    logic [15:0] x;
    int cand;
    bit done;
    x = s;
    done = 0;
    k = 0;
    idx = 0;
    for (int t = 0; t < mt_p[i] && !done; t++) begin
      cand = int'(x & 16'h001F);
      if (cand < 18 && !(norep_p[i] != 0 && m_lv[i] && cand == m_li[i])) begin
        k = t + 1;
        idx = cand;
        done = 1;
      end else if (t + 1 == mt_p[i]) begin
        k = t + 1;
        idx = m_lv[i] ? ((m_li[i] == 17) ? 0 : m_li[i] + 1) : 0;
        done = 1;
      end else begin
        x = step(x);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (seed_load) m_lfsr = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
    else           m_lfsr = step(m_lfsr);
    #1;
  endtask

  task automatic resync();
    reset = 1'b1;
    req = 1'b0;
    seed_load = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_lfsr = 16'd42;
    for (int i = 0; i < N; i++) begin
      m_lv[i] = 0;
      m_li[i] = 0;
    end
  endtask

  task automatic do_draw(input bit ld, input logic [15:0] sd);
    int ek [N];
    int ei [N];
    req = 1'b1;
    seed_load = ld;
    seed_in = sd;
    tick();
    req = 1'b0;
    seed_load = 1'b0;
    for (int i = 0; i < N; i++) begin
      predict(i, m_lfsr, ek[i], ei[i]);
      act_k[i] = 0;
      act_v[i] = -1;
      chk($sformatf("busy_start[%0d]", i), busy_o[i], 1);
      chk($sformatf("valid_start[%0d]", i), valid_o[i], 0);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (valid_o[i] && act_k[i] == 0) begin
          act_k[i] = j;
          act_v[i] = rv_o[i];
        end
        chk($sformatf("valid[%0d]@%0d", i, j), valid_o[i], (j == ek[i]) ? 1 : 0);
        chk($sformatf("busy[%0d]@%0d", i, j), busy_o[i], (j < ek[i]) ? 1 : 0);
        if (j == ek[i]) chk($sformatf("value[%0d]", i), rv_o[i], off_p[i] + ei[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("held[%0d]", i), rv_o[i], off_p[i] + ei[i]);
      m_lv[i] = 1;
      m_li[i] = ei[i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    int ev [N];
    int ek [N];
    tbl[0] = '{16'h0005,  5,  5,  8,  5, 1, 1, 1, 1};
    tbl[1] = '{16'h0005,  5,  2,  8,  5, 1, 2, 1, 1};
    tbl[2] = '{16'h0017, 11, 11, 14,  6, 2, 2, 2, 1};
    tbl[3] = '{16'h0000,  1,  1,  4,  1, 1, 1, 1, 1};
    tbl[4] = '{16'h0011, 17, 17, 20, 17, 1, 1, 1, 1};
    tbl[5] = '{16'h0017, 11, 11, 14,  0, 2, 2, 2, 1};

    // reset state
    reset = 1'b1;
    req = 1'b0;
    seed_load = 1'b0;
    seed_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_busy[%0d]", i), busy_o[i], 0);
      chk($sformatf("rst_valid[%0d]", i), valid_o[i], 0);
      chk($sformatf("rst_value[%0d]", i), rv_o[i], off_p[i]);
    end
    chk("rst_lfsr", u0.lfsr, 16'h002A);
    reset = 1'b0;
    m_lfsr = 16'd42;
    for (int i = 0; i < N; i++) m_lv[i] = 0;
    tick();
    chk("lfsr_1", u0.lfsr, 16'h0015);
    tick();
    chk("lfsr_2", u0.lfsr, 16'hB40A);
    chk("idle_valid", valid_o[0], 0);

    // directed vectors: seed_load with req in the same idle cycle
    for (int t = 0; t < 6; t++) begin
      do_draw(1'b1, tbl[t].seed);
      ev = '{tbl[t].v0, tbl[t].v1, tbl[t].v2, tbl[t].v3};
      ek = '{tbl[t].k0, tbl[t].k1, tbl[t].k2, tbl[t].k3};
      for (int i = 0; i < N; i++) begin
        chk($sformatf("tbl%0d_value[%0d]", t, i), act_v[i], ev[i]);
        chk($sformatf("tbl%0d_lat[%0d]", t, i), act_k[i], ek[i]);
      end
    end

    // req held high: next draw starts on the edge after the valid edge
    resync();
    req = 1'b1;
    seed_load = 1'b1;
    seed_in = 16'h0005;
    tick();
    seed_load = 1'b0;
    chk("hold_busy_e0", busy_o[0], 1);
    tick();
    chk("hold_valid_e1", valid_o[0], 1);
    chk("hold_value_e1", rv_o[0], 5);
    chk("hold_busy_e1", busy_o[0], 0);
    tick();
    chk("hold_valid_e2", valid_o[0], 0);
    chk("hold_busy_e2", busy_o[0], 1);
    tick();
    chk("hold_valid_e3", valid_o[0], 1);
    chk("hold_value_e3", rv_o[0], 1);
    req = 1'b0;

    // reseed in the middle of a draw
    resync();
    req = 1'b1;
    seed_load = 1'b1;
    seed_in = 16'h0017;
    tick();
    req = 1'b0;
    seed_in = 16'h0003;
    tick();
    seed_load = 1'b0;
    chk("reseed_valid_e1", valid_o[0], 0);
    chk("reseed_busy_e1", busy_o[0], 1);
    tick();
    chk("reseed_valid_e2", valid_o[0], 1);
    chk("reseed_value_e2", rv_o[0], 3);

    // asynchronous reset during a draw
    resync();
    req = 1'b1;
    seed_load = 1'b1;
    seed_in = 16'h0017;
    tick();
    req = 1'b0;
    seed_load = 1'b0;
    for (int i = 0; i < N; i++) chk($sformatf("mid_busy[%0d]", i), busy_o[i], 1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("arst_busy[%0d]", i), busy_o[i], 0);
      chk($sformatf("arst_valid[%0d]", i), valid_o[i], 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_lfsr = 16'd42;
    for (int i = 0; i < N; i++) m_lv[i] = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        chk($sformatf("post_rst_valid[%0d]", i), valid_o[i], 0);
        chk($sformatf("post_rst_busy[%0d]", i), busy_o[i], 0);
      end
    end

    // randomized draws against the reference model
    for (int it = 0; it < 150; it++) begin
      int idle_n;
      idle_n = $urandom_range(0, 3);
      for (int c = 0; c < idle_n; c++) begin
        seed_load = ($urandom_range(0, 3) == 0);
        seed_in = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom());
        tick();
        seed_load = 1'b0;
        for (int i = 0; i < N; i++) begin
          chk($sformatf("rnd_idle_valid[%0d]", i), valid_o[i], 0);
          chk($sformatf("rnd_idle_busy[%0d]", i), busy_o[i], 0);
        end
      end
      do_draw(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_draw.md
Name: rng_draw

Overview:
- Parametrised successor to the free-running rng: a Galois LFSR with request/valid draw handshake.
- Produces bias-free values in [OFFSET, OFFSET+MAX_VALUE-1] by rejection sampling, not by truncation.
- Adds runtime reseed (e.g. from player button timing) and an optional no-repeat mode so the same mole hole is never chosen twice in a row.
- Sits between the game FSM and the mole/hole selection logic.

Parameters:
- LFSR_WIDTH, 16, width of LFSR state.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 42, state loaded on reset; 0 is replaced by 1.
- OFFSET, 0, added to accepted index.
- MAX_VALUE, 18, number of distinct outputs; must be >=2. IDX_W = $clog2(MAX_VALUE), must be <= LFSR_WIDTH.
- NO_REPEAT, 0, 1 = reject candidate equal to previous output index.
- MAX_TRIES, 8, rejections before deterministic fallback; >=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  draw request, sampled only in IDLE.
- seed_load  in  1  load seed_in into LFSR this edge.
- seed_in  in  LFSR_WIDTH  new seed.
- busy  out  1  high while in DRAW.
- valid  out  1  one-cycle pulse; random_value updated on same edge.
- random_value  out  $clog2(OFFSET+MAX_VALUE)  last drawn value, held between draws.

Behaviour:
- Reset, asynchronous and active-high:
  - lfsr = (SEED==0 ? 1 : SEED); FSM=IDLE.
  - busy=0, valid=0, random_value=OFFSET.
  - last_valid=0, try counter=0.
- LFSR (every edge, not in reset):
  - If seed_load: lfsr <= (seed_in==0 ? 1 : seed_in); this takes priority over shifting.
  - Else Galois step: b=lfsr[0]; lfsr <= (lfsr>>1) ^ (b ? TAPS : 0).
  - The LFSR never reaches 0.
- candidate = lfsr[IDX_W-1:0], taken from the pre-edge state.
- FSM IDLE:
  - req=1 -> DRAW, tries=0. busy goes high on that edge.
  - req=0 -> stay.
  - valid is always 0 in IDLE except during the pulse cycle.
- FSM DRAW (each edge):
  - Candidate is rejected if candidate >= MAX_VALUE, or if (NO_REPEAT && last_valid && candidate==last_idx).
  - Accept:
    - random_value <= OFFSET+candidate; last_idx <= candidate; last_valid <= 1.
    - valid <= 1 for one cycle; -> IDLE; busy <= 0.
  - Reject with tries+1 < MAX_TRIES: tries++, stay in DRAW.
  - Reject with tries+1 == MAX_TRIES: fallback.
    - fb = last_valid ? (last_idx==MAX_VALUE-1 ? 0 : last_idx+1) : 0.
    - Output OFFSET+fb with a valid pulse, update last_idx, -> IDLE.
    - The fallback never repeats and is always in range.
- Latency:
  - req sampled at edge E0; valid at edge E1 at the earliest.
  - Worst case valid at edge E(MAX_TRIES).
- req during DRAW is ignored; no queuing.
- req held high: a new draw starts on the edge after the valid edge, so at most one value per 2 cycles.
- seed_load during DRAW: the FSM continues; the next evaluated candidate comes from the new seed.
- seed_load and req on the same edge in IDLE: seed loaded and DRAW entered; the first candidate is seed_in[IDX_W-1:0] (or 1 for a zero seed).
- Reset mid-DRAW: immediate return to the reset state; no valid pulse; last_valid cleared.
- Arithmetic: OFFSET+candidate is computed at output width; no overflow is possible by the width definition.

Test Plan (defaults unless stated; each case: seed_load=1 with req=1 in the same IDLE cycle):
- Reset with SEED=42: check busy=0, valid=0, random_value=0. Then the next two free-running LFSR states must be 0x0015 and 0xB40A.
- seed_in=0x0005: busy high one cycle; valid pulse on the next edge; random_value=5; busy low.
- seed_in=0x0017: candidate 23 is rejected; the next state 0xB40B gives candidate 11. Valid comes exactly 2 edges after the req edge with random_value=11.
- NO_REPEAT=1: draw 5 via seed 0x0005, then repeat the same seed+req. Candidate 5 is rejected; next state 0xB402 gives random_value=2 after 2 edges.
- seed_in=0x0000: LFSR loads 1; random_value=1. Separately, OFFSET=3: seed 0x0005 gives random_value=8.
- MAX_TRIES=1, seed_in=0x0017 after a prior output of 17: fallback wraps, random_value=0, valid on the first DRAW edge. Then assert reset during DRAW: busy=0 and valid=0 immediately, no pulse afterwards.
